// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control unit: IF/ID/EX/MEM/WB sequencer with ALU-control decode.
// Optional PERF_CNT_EN adds cycle and retired-instruction counters.
module multicycle_ctrl #(
   parameter int unsigned ALUCTRL_W   = 4,
   parameter int unsigned TIMEOUT_W   = 8,
   parameter int unsigned MEM_TIMEOUT = 200,
   parameter int unsigned SKIP_MEM    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          instr,
   input  logic                 imem_ready,
   input  logic                 dmem_ready,
   input  logic                 zero,
   input  logic                 lt,
   output logic                 loadPC,
   output logic                 PCSrc,
   output logic                 ALUSrc,
   output logic [ALUCTRL_W-1:0] ALUCtrl,
   output logic                 MemRead,
   output logic                 MemWrite,
   output logic                 MemToReg,
   output logic                 RegWrite,
   output logic [2:0]           state,
   output logic                 illegal,
   output logic                 timeout
`ifdef PERF_CNT_EN
   ,
   output logic [31:0]          cycle_cnt,
   output logic [31:0]          instret_cnt
`endif
);

   typedef enum logic [2:0] {
      S_IF  = 3'b000,
      S_ID  = 3'b001,
      S_EX  = 3'b010,
      S_MEM = 3'b011,
      S_WB  = 3'b100,
      S_ERR = 3'b111
   } state_t;

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011;
   localparam logic [6:0] OP_BR = 7'b1100011;

   state_t               cur, nxt;
   logic [31:0]          ir, ir_nxt;
   logic [TIMEOUT_W-1:0] cnt, cnt_nxt;
   logic                 taken, taken_nxt;
   logic                 illegal_nxt, timeout_nxt;

   logic [6:0] opcode;
   logic [2:0] f3;
   logic       b30;
   logic       is_r, is_i, is_ld, is_st, is_br, is_mem;
   logic       legal, br_cond, timeout_hit;
   logic [3:0] alu_code;

   assign opcode = ir[6:0];
   assign f3     = ir[14:12];
   assign b30    = ir[30];
   assign state  = cur;

   logic unused_ir;
   assign unused_ir = ^{ir[31], ir[29:15], ir[11:7]};

   // Instruction class, legality, branch outcome and ALU operation from the latched ir
   always_comb begin
      is_r     = (opcode == OP_R);
      is_i     = (opcode == OP_I);
      is_ld    = (opcode == OP_LD);
      is_st    = (opcode == OP_ST);
      is_br    = (opcode == OP_BR);
      is_mem   = is_ld | is_st;
      legal    = ((is_r | is_i) && (f3 != 3'b011)) || is_mem ||
                 (is_br && ((f3 == 3'b000) || (f3 == 3'b001) ||
                            (f3 == 3'b100) || (f3 == 3'b101)));
      br_cond  = 1'b0;
      alu_code = 4'b0010;
      case (f3)
         3'b000:  br_cond = zero;
         3'b001:  br_cond = ~zero;
         3'b100:  br_cond = lt;
         3'b101:  br_cond = ~lt;
         default: br_cond = 1'b0;
      endcase
      if (is_br) begin
         alu_code = 4'b0110;
      end else if (is_r | is_i) begin
         case (f3)
            3'b000:  alu_code = (is_r && b30) ? 4'b0110 : 4'b0010;
            3'b111:  alu_code = 4'b0000;
            3'b110:  alu_code = 4'b0001;
            3'b100:  alu_code = 4'b0101;
            3'b001:  alu_code = 4'b1001;
            3'b101:  alu_code = b30 ? 4'b1010 : 4'b1000;
            3'b010:  alu_code = 4'b0100;
            default: alu_code = 4'b0010;
         endcase
      end
   end

   // Last permitted wait cycle; a zero MEM_TIMEOUT never fires
   assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt == TIMEOUT_W'(MEM_TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur     <= S_IF;
         ir      <= '0;
         cnt     <= '0;
         taken   <= 1'b0;
         illegal <= 1'b0;
         timeout <= 1'b0;
      end else begin
         cur     <= nxt;
         ir      <= ir_nxt;
         cnt     <= cnt_nxt;
         taken   <= taken_nxt;
         illegal <= illegal_nxt;
         timeout <= timeout_nxt;
      end
   end

   // Next-state and housekeeping register updates
   always_comb begin
      nxt         = cur;
      ir_nxt      = ir;
      cnt_nxt     = cnt;
      taken_nxt   = taken;
      illegal_nxt = illegal;
      timeout_nxt = timeout;
      case (cur)
         S_IF: begin
            if (imem_ready) begin
               ir_nxt  = instr;
               cnt_nxt = '0;
               nxt     = S_ID;
            end else if (timeout_hit) begin
               timeout_nxt = 1'b1;
               nxt         = S_ERR;
            end else begin
               cnt_nxt = cnt + TIMEOUT_W'(1);
            end
         end
         S_ID: begin
            if (!legal) begin
               illegal_nxt = 1'b1;
               nxt         = S_ERR;
            end else begin
               nxt = S_EX;
            end
         end
         S_EX: begin
            if (is_br) taken_nxt = br_cond;
            if (is_mem || (SKIP_MEM == 0)) begin
               cnt_nxt = '0;
               nxt     = S_MEM;
            end else begin
               nxt = S_WB;
            end
         end
         S_MEM: begin
            if (!is_mem || dmem_ready) begin
               nxt = S_WB;
            end else if (timeout_hit) begin
               timeout_nxt = 1'b1;
               nxt         = S_ERR;
            end else begin
               cnt_nxt = cnt + TIMEOUT_W'(1);
            end
         end
         S_WB: begin
            taken_nxt = 1'b0;
            cnt_nxt   = '0;
            nxt       = S_IF;
         end
         S_ERR:   nxt = S_ERR;
         default: nxt = S_ERR;
      endcase
   end

   // Datapath controls decoded from state and ir only
   always_comb begin
      loadPC   = 1'b0;
      PCSrc    = 1'b0;
      ALUSrc   = 1'b0;
      ALUCtrl  = '0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      MemToReg = 1'b0;
      RegWrite = 1'b0;
      if ((cur == S_ID) || (cur == S_EX) || (cur == S_MEM) || (cur == S_WB)) begin
         ALUCtrl = ALUCTRL_W'(alu_code);
         ALUSrc  = is_ld | is_i | is_st;
      end
      if (cur == S_MEM) begin
         MemRead  = is_ld;
         MemWrite = is_st;
      end
      if (cur == S_WB) begin
         loadPC   = 1'b1;
         PCSrc    = is_br & taken;
         RegWrite = is_r | is_i | is_ld;
         MemToReg = is_ld;
      end
   end

`ifdef PERF_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cycle_cnt   <= '0;
         instret_cnt <= '0;
      end else begin
         if (cur != S_ERR) cycle_cnt <= cycle_cnt + 32'(1);
         if (cur == S_WB) instret_cnt <= instret_cnt + 32'(1);
      end
   end
`endif

endmodule
